// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : memory/writeback stage with stall, req/ready data port and
//                access watchdog.  Rev 1.0
// ============================================================================
module mem_wb_stage #(
  parameter int MEM_BASE = 1024,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [3:0]        in_dest,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              wb_en,
  output logic [3:0]        wb_dest,
  output logic [31:0]       wb_value,
  output logic              mem_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [0:0]         c_IDLE     = 1'b0;
  localparam logic [0:0]         c_ACCESS   = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_acc_dest;
  logic               r_acc_wb_en;
  logic               r_wb_en;
  logic [3:0]         r_wb_dest;
  logic [31:0]        r_wb_value;
  logic               r_mem_err;

  logic w_is_mem;
  logic w_accept;
  logic w_done;
  logic w_abort;

  assign w_is_mem = in_mem_r_en | in_mem_w_en;
  assign w_accept = (r_state == c_IDLE) & in_valid;
  assign w_done   = (r_state == c_ACCESS) & mem_ready;
  assign w_abort  = (r_state == c_ACCESS) & ~mem_ready & (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_accept && w_is_mem) w_state_nxt = c_ACCESS;
      c_ACCESS: if (w_done || w_abort)    w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // stall drops in the completing or aborting cycle so upstream advances with us
  always_comb begin
    mem_req = 1'b0;
    stall   = 1'b0;
    case (r_state)
      c_IDLE:   stall = in_valid & w_is_mem;
      c_ACCESS: begin
        mem_req = 1'b1;
        stall   = ~mem_ready & ~w_abort;
      end
      default: begin
        mem_req = 1'b0;
        stall   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_mem) begin
      r_cnt <= '0;
    end else if ((r_state == c_ACCESS) && !mem_ready && !w_abort) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Writebacks to R15 are dropped: the register file only holds R0-R14
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_acc_dest  <= '0;
      r_acc_wb_en <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_value  <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_wb_en   <= 1'b0;
      r_mem_err <= 1'b0;
      if (w_accept) begin
        if (w_is_mem) begin
          r_mem_we    <= ~in_mem_r_en;
          r_mem_addr  <= ADDR_W'((in_alu_result - 32'(MEM_BASE)) >> 2);
          r_mem_wdata <= in_store_data;
          r_acc_dest  <= in_dest;
          r_acc_wb_en <= in_wb_en;
        end else begin
          r_wb_en    <= in_wb_en & (in_dest != 4'd15);
          r_wb_dest  <= in_dest;
          r_wb_value <= in_alu_result;
        end
      end
      if (w_done && !r_mem_we) begin
        r_wb_en    <= r_acc_wb_en & (r_acc_dest != 4'd15);
        r_wb_dest  <= r_acc_dest;
        r_wb_value <= mem_rdata;
      end
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_en     = r_wb_en;
  assign wb_dest   = r_wb_dest;
  assign wb_value  = r_wb_value;
  assign mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_wb_stage : scoreboard bench for mem_wb_stage (directed + random).
// Rev 1.0
// ============================================================================
module tb_mem_wb_stage;

  localparam int c_TO   = 4;
  localparam int c_BASE = 1024;

  logic        clk;
  logic        rst;
  logic        in_valid, in_wb_en, in_mem_r_en, in_mem_w_en;
  logic [31:0] in_alu_result, in_store_data;
  logic [3:0]  in_dest;
  logic        stall, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        mem_err;

  mem_wb_stage #(.MEM_BASE(c_BASE), .ADDR_W(8), .TIMEOUT(c_TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wb_en(in_wb_en),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_dest(in_dest), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .mem_err(mem_err)
  );

  typedef struct { bit is_err; logic [3:0] dest; logic [31:0] value; } ev_t;
  typedef struct { logic we; logic [7:0] addr; logic [31:0] wdata; } acc_t;

  ev_t  evq[$];
  acc_t accq[$];
  acc_t cur_acc;
  int   checks   = 0;
  int   failures = 0;
  int   req_cycles = 0;
  bit   prev_req = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Byte address to word address: ((alu - base) mod 2^32) / 4, modulo 256 words
  function automatic logic [7:0] exp_addr(input logic [31:0] alu);
    logic [31:0] off;
    off = alu - 32'(c_BASE);
    return 8'((off / 4) % 256);
  endfunction

  // Monitor: every wb_en / mem_err / active request is compared against the queues
  always @(negedge clk) begin
    if (rst) begin
      if (wb_en) begin
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected actual dest=%0d value=%h required none", wb_dest, wb_value);
        end else begin
          ev_t e;
          e = evq.pop_front();
          if (e.is_err || wb_dest !== e.dest || wb_value !== e.value) begin
            failures++;
            $display("FAIL wb_event actual wb dest=%0d value=%h required err=%0d dest=%0d value=%h",
                     wb_dest, wb_value, e.is_err, e.dest, e.value);
          end
        end
      end
      if (mem_err) begin
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL err_unexpected actual mem_err=1 required none");
        end else begin
          ev_t e;
          e = evq.pop_front();
          if (!e.is_err) begin
            failures++;
            $display("FAIL err_event actual mem_err=1 required wb dest=%0d value=%h", e.dest, e.value);
          end
        end
      end
      if (mem_req) begin
        req_cycles++;
        if (!prev_req) begin
          if (accq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual addr=%h required no request", mem_addr);
          end else begin
            cur_acc = accq.pop_front();
          end
        end
        checks++;
        if (mem_we !== cur_acc.we || mem_addr !== cur_acc.addr || mem_wdata !== cur_acc.wdata) begin
          failures++;
          $display("FAIL req_fields actual we=%0d addr=%h wdata=%h required we=%0d addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, cur_acc.we, cur_acc.addr, cur_acc.wdata);
        end
      end
      prev_req = mem_req;
    end else begin
      prev_req = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid      = 0;
    in_wb_en      = 1'($urandom);
    in_mem_r_en   = 1'($urandom);
    in_mem_w_en   = 1'($urandom);
    in_alu_result = $urandom;
    in_dest       = 4'($urandom);
    mem_ready     = 1'($urandom);
    mem_rdata     = $urandom;
    @(negedge clk);
    chk("stall_idle", 32'(stall), 0);
    next_cycle();
  endtask

  task automatic do_nonmem(input logic [3:0] dest, input logic [31:0] val, input logic wben);
    in_valid      = 1;
    in_mem_r_en   = 0;
    in_mem_w_en   = 0;
    in_wb_en      = wben;
    in_dest       = dest;
    in_alu_result = val;
    in_store_data = $urandom;
    mem_ready     = 1'($urandom);
    @(negedge clk);
    chk("stall_nonmem", 32'(stall), 0);
    if (wben && dest != 4'd15) evq.push_back(ev_t'{1'b0, dest, val});
    next_cycle();
  endtask

  // k = ACCESS cycle in which mem_ready rises; k = 0 means never (watchdog abort)
  task automatic do_mem(input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] data, input logic [3:0] dest,
                        input logic wben, input int k, input logic [31:0] rdata);
    bit done;
    in_valid      = 1;
    in_mem_r_en   = r;
    in_mem_w_en   = w;
    in_wb_en      = wben;
    in_dest       = dest;
    in_alu_result = alu;
    in_store_data = data;
    mem_ready     = 1'($urandom);
    accq.push_back(acc_t'{~r, exp_addr(alu), data});
    @(negedge clk);
    chk("stall_accept", 32'(stall), 1);
    next_cycle();
    done = 0;
    for (int i = 1; i <= c_TO && !done; i++) begin
      in_valid      = 1'($urandom);
      in_mem_r_en   = 1'($urandom);
      in_mem_w_en   = 1'($urandom);
      in_wb_en      = 1'($urandom);
      in_dest       = 4'($urandom);
      in_alu_result = $urandom;
      in_store_data = $urandom;
      mem_ready     = (i == k);
      mem_rdata     = rdata;
      @(negedge clk);
      if (i == k) begin
        chk("stall_complete", 32'(stall), 0);
        if (r && wben && dest != 4'd15) evq.push_back(ev_t'{1'b0, dest, rdata});
        done = 1;
      end else if (k == 0 && i == c_TO) begin
        chk("stall_abort", 32'(stall), 0);
        evq.push_back(ev_t'{1'b1, 4'd0, 32'd0});
        done = 1;
      end else begin
        chk("stall_access", 32'(stall), 1);
      end
      next_cycle();
    end
    mem_ready = 0;
  endtask

  initial begin
    int rc;
    rst = 0;
    in_valid = 0; in_wb_en = 0; in_mem_r_en = 0; in_mem_w_en = 0;
    in_alu_result = 0; in_store_data = 0; in_dest = 0;
    mem_rdata = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1;
    next_cycle();

    do_nonmem(4'd3, 32'h0000_002A, 1'b1);
    idle_cycle();

    rc = req_cycles;
    do_mem(1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, 1'b1, 3, 32'hDEAD_BEEF);
    chk("load_req_cycles", 32'(req_cycles - rc), 3);
    idle_cycle();

    rc = req_cycles;
    do_mem(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 4'd6, 1'b1, 1, 32'hFFFF_FFFF);
    chk("store_req_cycles", 32'(req_cycles - rc), 1);
    idle_cycle();

    rc = req_cycles;
    do_mem(1'b1, 1'b0, 32'd1100, 32'h0, 4'd7, 1'b1, 0, 32'h5555_AAAA);
    chk("abort_req_cycles", 32'(req_cycles - rc), c_TO);
    idle_cycle();

    do_nonmem(4'd15, 32'h0BAD_F00D, 1'b1);
    idle_cycle();

    do_mem(1'b1, 1'b1, 32'd1040, 32'h7777_7777, 4'd2, 1'b1, 2, 32'hCAFE_0001);
    do_mem(1'b1, 1'b0, 32'd1044, 32'h0, 4'd15, 1'b1, 1, 32'hCAFE_0002);

    // Reset during the 2nd ACCESS cycle
    in_valid = 1; in_mem_r_en = 1; in_mem_w_en = 0; in_wb_en = 1;
    in_dest = 4'd9; in_alu_result = 32'd1048; in_store_data = 32'h0; mem_ready = 0;
    accq.push_back(acc_t'{1'b0, exp_addr(32'd1048), 32'h0});
    next_cycle();
    in_valid = 0;
    next_cycle();
    #2 rst = 0;
    #1 chk("rst_mid_req", 32'(mem_req), 0);
    @(negedge clk);
    #1 rst = 1;
    chk("post_rst_wb_en", 32'(wb_en), 0);
    chk("post_rst_mem_err", 32'(mem_err), 0);
    chk("post_rst_wb", {wb_dest, wb_value[27:0]} | {28'd0, wb_value[31:28]}, 0);
    chk("post_rst_mem", {23'd0, mem_we, mem_addr} | mem_wdata, 0);
    next_cycle();
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [31:0] alu;
      sel = $urandom_range(0, 9);
      alu = ($urandom_range(0, 3) == 0) ? $urandom : 32'(c_BASE) + 32'($urandom_range(0, 2047));
      if (sel < 4) begin
        do_nonmem(4'($urandom), $urandom, 1'($urandom));
      end else if (sel < 9) begin
        logic r, w;
        r = 1'($urandom);
        w = r ? 1'($urandom) : 1'b1;
        do_mem(r, w, alu, $urandom, 4'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, c_TO), $urandom);
      end else begin
        idle_cycle();
      end
    end

    repeat (3) idle_cycle();
    chk("evq_drained", evq.size(), 0);
    chk("accq_drained", accq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
